timer_display: RTL and testbench
================================

// Module: timer_display
// PURPOSE
//  Downstream consumer of the stopwatch/timer count (12-bit mm:ss: [11:6] minutes, [5:0] seconds).
//  On an update strobe it snapshots the count and converts each field to two BCD digits with a
//  multi-cycle subtract-10 FSM. It then time-multiplexes four 7-segment digits (MM.SS) and blinks
//  the display while time_up is asserted. Feeds the chip's seven-segment pad outputs.
// PARAMETERS
//  SCAN_DIV   1000  clk cycles each digit stays selected (>=2)
//  BLINK_DIV  64    full 4-digit scan rounds per blink half-period (>=1)
// PORTS
//  clk        in   1   system clock
//  nrst       in   1   reset, asynchronous, active-low
//  timer_in   in   12  count to display: [11:6] minutes 0..63, [5:0] seconds 0..63
//  time_up    in   1   level; while high the display blinks
//  update     in   1   single-cycle strobe: snapshot timer_in and convert
//  busy       out  1   conversion in progress (state != IDLE)
//  seg        out  7   segment drive, active-high, bit0=a .. bit6=g
//  dp         out  1   decimal point, active-high (MM.SS separator)
//  digit_sel  out  4   one-hot digit enable, active-high; bit0 = seconds ones .. bit3 = minutes tens
// BEHAVIOUR
//  Reset: state IDLE, busy=0, BCD display regs all 0, digit index 0, scan/blink counters 0,
//   blink phase visible -> digit_sel=4'b0001, seg=7'h3F, dp=0.
//  FSM IDLE -> CONV_MIN -> CONV_SEC -> LOAD -> IDLE:
//   IDLE: update=1 at edge -> latch timer_in into rem_m/rem_s, clear working tens, go CONV_MIN.
//   CONV_MIN: rem_m>=10 -> rem_m-=10, tens_m+=1 (stay); else ones_m=rem_m, go CONV_SEC.
//   CONV_SEC: same on rem_s; when rem_s<10, ones_s=rem_s, go LOAD.
//   LOAD: copy working digits into the 4 display regs in one edge, go IDLE.
//  Latency: display regs change at edge E0+3+tm+ts (E0 = edge sampling update; tm/ts = tens
//   digits); min 3, max 15 (63:63). Display holds old value until LOAD; never shows partial digits.
//  update while busy=1: ignored; no queueing. timer_in is only sampled at E0.
//  Field values 60..63 are displayed literally (tens digit 6); no clamping.
//  Scan: scan_cnt counts 0..SCAN_DIV-1, runs continuously, including during conversion.
//   On wrap it advances the digit index 0->1->2->3->0. digit_sel=1<<index.
//   seg=decode(display reg[index]). dp=1 only when index==2.
//  Decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; codes >9 -> 00.
//  Blink: while time_up=1, blink_cnt counts index 3->0 wraps. Every BLINK_DIV wraps blink phase
//   toggles. Blank phase forces seg=0, dp=0, digit_sel=0. Scanning continues underneath.
//   First toggle to blank occurs after BLINK_DIV rounds.
//  time_up=0: blink_cnt cleared and phase forced visible on the next edge.
//  seg/dp/digit_sel are combinational decodes of registered state only (glitch-free wrt inputs).
//  Reset mid-conversion: immediate return to reset state; the partial result is discarded.
// TESTING (bench uses SCAN_DIV=4, BLINK_DIV=2)
//  Reset release -> busy=0, digit_sel=0001, seg=3F, dp=0; digit_sel steps 0010 after 4 clks.
//  timer_in=362 (05:42), update pulse -> busy high 7 cycles; then digits 0..3 show
//   seg 5B,66,6D(dp=1),3F.
//  timer_in=4095 (63:63), update -> display changes exactly 15 edges after E0;
//   digits show 3,6,3,6 = 4F,7D,4F,7D.
//  Second update 2 cycles after first with different timer_in -> ignored; first value displayed.
//  time_up=1 held -> visible 32 clks, blank (digit_sel=0, seg=0) 32 clks, repeating;
//   time_up=0 -> visible next cycle.
//  nrst asserted during CONV_SEC -> busy=0 and digits 00.00 immediately; later update converts normally.

Source files
------------

// File: rtl/timer_display.sv
// Converts a snapshotted mm:ss count into four BCD digits with a subtract-10 FSM.
// Scans the digits onto a multiplexed 7-segment display and blinks it while time_up is high.
module timer_display #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [11:0] timer_in,
  input  logic        time_up,
  input  logic        update,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  digit_sel
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned FIELD_W = 6;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV_MIN = 2'd1,
    CONV_SEC = 2'd2,
    LOAD     = 2'd3
  } state_t;

  state_t                          state;
  logic [FIELD_W-1:0]              rem_m;
  logic [FIELD_W-1:0]              rem_s;
  logic [DIGIT_W-1:0]              tens_m;
  logic [DIGIT_W-1:0]              ones_m;
  logic [DIGIT_W-1:0]              tens_s;
  logic [DIGIT_W-1:0]              ones_s;
  logic [3:0][DIGIT_W-1:0]         disp;

  logic [SCAN_W-1:0]               scan_cnt;
  logic [1:0]                      digit_idx;
  logic [BLINK_W-1:0]              blink_cnt;
  logic                            blank;
  logic                            scan_wrap;
  logic                            round_wrap;

  function automatic logic [6:0] seg_decode(input logic [DIGIT_W-1:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Conversion FSM: display regs only change in LOAD, so partial digits never show.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      rem_m  <= '0;
      rem_s  <= '0;
      tens_m <= '0;
      ones_m <= '0;
      tens_s <= '0;
      ones_s <= '0;
      disp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (update) begin
            rem_m  <= timer_in[11:6];
            rem_s  <= timer_in[5:0];
            tens_m <= '0;
            tens_s <= '0;
            state  <= CONV_MIN;
            busy   <= 1'b1;
          end
        end
        CONV_MIN: begin
          if (rem_m >= FIELD_W'(10)) begin
            rem_m  <= rem_m - FIELD_W'(10);
            tens_m <= tens_m + DIGIT_W'(1);
          end else begin
            ones_m <= rem_m[DIGIT_W-1:0];
            state  <= CONV_SEC;
          end
        end
        CONV_SEC: begin
          if (rem_s >= FIELD_W'(10)) begin
            rem_s  <= rem_s - FIELD_W'(10);
            tens_s <= tens_s + DIGIT_W'(1);
          end else begin
            ones_s <= rem_s[DIGIT_W-1:0];
            state  <= LOAD;
          end
        end
        LOAD: begin
          disp[0] <= ones_s;
          disp[1] <= tens_s;
          disp[2] <= ones_m;
          disp[3] <= tens_m;
          state   <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign round_wrap = scan_wrap && (digit_idx == 2'd3);

  // Digit scan runs free, independent of conversion and blinking.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_wrap) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  // Blink phase toggles every BLINK_DIV full scan rounds; dropping time_up restores visibility.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (!time_up) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (round_wrap) begin
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blank     <= ~blank;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    seg       = 7'h00;
    dp        = 1'b0;
    digit_sel = 4'b0000;
    if (!blank) begin
      digit_sel = 4'b0001 << digit_idx;
      seg       = seg_decode(disp[digit_idx]);
      dp        = (digit_idx == 2'd2);
    end
  end

endmodule

// File: tb/tb_timer_display.sv
// Self-checking bench for timer_display: cycle-level behavioural model plus directed literal checks.
module tb_timer_display;

  localparam int SD = 4;
  localparam int BD = 2;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk;
  logic        nrst;
  logic [11:0] timer_in;
  logic        time_up;
  logic        update;
  logic        busy;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;

  int total;
  int bad;

  timer_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .timer_in  (timer_in),
    .time_up   (time_up),
    .update    (update),
    .busy      (busy),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: e = edges since reset; display digits come from /10 and %10 after the stated latency.
  int         e;
  int         done_at;
  bit         busy_m;
  int         wraps;
  logic [3:0] disp_m [4];
  logic [3:0] pend   [4];

  always @(posedge clk or negedge nrst) begin
    int m;
    int s;
    if (!nrst) begin
      e = 0;
      done_at = 0;
      busy_m = 1'b0;
      wraps = 0;
      for (int i = 0; i < 4; i++) disp_m[i] = 4'd0;
    end else begin
      e = e + 1;
      if (time_up) begin
        if (e % (4 * SD) == 0) wraps = wraps + 1;
      end else begin
        wraps = 0;
      end
      if (busy_m) begin
        if (e == done_at) begin
          for (int i = 0; i < 4; i++) disp_m[i] = pend[i];
          busy_m = 1'b0;
        end
      end else if (update) begin
        m = int'(timer_in[11:6]);
        s = int'(timer_in[5:0]);
        pend[0] = 4'(s % 10);
        pend[1] = 4'(s / 10);
        pend[2] = 4'(m % 10);
        pend[3] = 4'(m / 10);
        done_at = e + 3 + m / 10 + s / 10;
        busy_m = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int idx;
    bit blank;
    idx = (e / SD) % 4;
    blank = ((wraps / BD) % 2) == 1;
    chk("busy", int'(busy), int'(busy_m));
    chk("digit_sel", int'(digit_sel), blank ? 0 : (1 << idx));
    chk("seg", int'(seg), blank ? 0 : int'(SEG_TAB[disp_m[idx]]));
    chk("dp", int'(dp), (!blank && idx == 2) ? 1 : 0);
  endtask

  task automatic pulse(input logic [11:0] v);
    @(posedge clk); #2;
    timer_in = v;
    update = 1'b1;
    @(posedge clk); #2;
    update = 1'b0;
  endtask

  task automatic busy_len(input string name, input int exp);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk(name, cnt, exp);
  endtask

  task automatic wait_sel(input logic [3:0] v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (digit_sel == v) break;
    end
    chk("wait_sel", int'(digit_sel), int'(v));
  endtask

  task automatic check_digits(input string name, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] lit [4];
    lit[0] = s0; lit[1] = s1; lit[2] = s2; lit[3] = s3;
    for (int k = 0; k < 4; k++) begin
      wait_sel(4'(1 << k));
      chk(name, int'(seg), int'(lit[k]));
      chk("lit_dp", int'(dp), (k == 2) ? 1 : 0);
    end
  endtask

  initial begin
    int run;
    total = 0;
    bad = 0;
    nrst = 1'b0;
    update = 1'b0;
    time_up = 1'b0;
    timer_in = 12'd0;

    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    repeat (3) @(posedge clk);
    #2 nrst = 1'b1;

    // Reset state and first digit step.
    @(negedge clk);
    chk("rst_sel", int'(digit_sel), 1);
    chk("rst_seg", int'(seg), 'h3F);
    chk("rst_dp", int'(dp), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("rst_sel_hold", int'(digit_sel), 1);
    @(negedge clk);
    chk("rst_sel_step", int'(digit_sel), 2);

    // 05:42
    pulse(12'd362);
    busy_len("busy_0542", 7);
    check_digits("seg_0542", 7'h5B, 7'h66, 7'h6D, 7'h3F);

    // 63:63 worst case
    pulse(12'd4095);
    busy_len("busy_6363", 15);
    check_digits("seg_6363", 7'h4F, 7'h7D, 7'h4F, 7'h7D);

    // 09:24 then a second update two cycles later that must be ignored
    pulse(12'd600);
    @(posedge clk); #2;
    timer_in = 12'd362;
    update = 1'b1;
    @(posedge clk); #2;
    update = 1'b0;
    busy_len("busy_0924", 3);
    check_digits("seg_0924", 7'h66, 7'h5B, 7'h6F, 7'h3F);

    // Blink: blank and visible runs of BD*4*SD cycles
    @(posedge clk); #2 time_up = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (digit_sel == 4'd0) break;
    end
    run = 0;
    for (int i = 0; i < 100; i++) begin
      if (digit_sel != 4'd0) break;
      run++;
      @(negedge clk);
    end
    chk("blank_run", run, 32);
    run = 0;
    for (int i = 0; i < 100; i++) begin
      if (digit_sel == 4'd0) break;
      run++;
      @(negedge clk);
    end
    chk("visible_run", run, 32);
    chk("blank_seg", int'(seg), 0);
    @(posedge clk); #2 time_up = 1'b0;
    @(negedge clk);
    chk("blank_hold", int'(digit_sel), 0);
    @(negedge clk);
    chk("unblank_next", int'(digit_sel != 4'd0), 1);

    // Reset during CONV_SEC
    pulse(12'd4095);
    repeat (8) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_seg", int'(seg), 'h3F);
    chk("rst_mid_sel", int'(digit_sel), 1);
    @(posedge clk); #2 nrst = 1'b1;
    pulse(12'd362);
    busy_len("busy_after_rst", 7);
    check_digits("seg_after_rst", 7'h5B, 7'h66, 7'h6D, 7'h3F);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      update = ($urandom_range(0, 7) == 0);
      timer_in = 12'($urandom);
      if ($urandom_range(0, 9) == 0) timer_in = 12'd4095;
      if ($urandom_range(0, 149) == 0) time_up = ~time_up;
      if ($urandom_range(0, 799) == 0) begin
        nrst = 1'b0;
        @(posedge clk); #2;
        nrst = 1'b1;
      end
    end
    update = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
